alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have port reset  input  1  asynchronous, active-high; returns all state to reset values immediately.
REQ-003 The block SHALL have port instr_valid  input  1  an instruction is presented on opcode/operand_addr/dest.
REQ-004 The block SHALL have port instr_ready  output  1  high only in IDLE; an instruction is accepted on a rising edge with instr_valid&&instr_ready.
REQ-005 The block SHALL have port opcode  input  4  operation select (REQ-013).
REQ-006 The block SHALL have port operand_addr  input  11  word address of the memory operand.
REQ-007 The block SHALL have port dest  input  1  0 = result to W; 1 = result to memory.
REQ-008 The block SHALL have port mem_addr  output  11  address to the ram; registered.
REQ-009 The block SHALL have ports mem_wdata  output  16  and mem_we  output  1  carrying write data and write strobe to the ram.
REQ-010 The block SHALL have port mem_rdata  input  16  ram read data, valid the cycle after mem_addr is presented.
REQ-011 The block SHALL have ports carry_from_mem and zero_from_mem  input  1 each (ram status outputs), and carry_to_mem and zero_to_mem  output  1 each (ram status inputs, held continuously).
REQ-012 The block SHALL have ports wreg  output  16  (the W register), done  output  1  (one-cycle completion pulse), and illegal  output  1  (one-cycle pulse for undefined opcode).

Function
REQ-013 Opcodes SHALL be: 0 MOVF R=M; 1 MOVWF R=W, dest forced to 1; 2 ADDWF R=M+W; 3 SUBWF R=M-W; 4 ANDWF; 5 IORWF; 6 XORWF; 7 COMF R=~M; 8 INCF R=M+1; 9 DECF R=M-1; A RLF {M[14:0],C}; B RRF {C,M[15:1]}; C CLRF R=0; D-F are illegal.
REQ-014 The FSM SHALL have states IDLE, READ, EXEC, and WB, with transitions IDLE->READ on accept, READ->EXEC, EXEC->WB, and WB->IDLE; no state SHALL stall.
REQ-015 Latency SHALL be fixed: with accept at edge k, mem_addr=operand_addr is driven during READ (k..k+1), mem_rdata and carry_from_mem are sampled at end of EXEC (edge k+2), and done is high during WB (k+2..k+3).
REQ-016 ALU arithmetic SHALL be 16-bit, modulo 2^16; the C input for RLF/RRF SHALL be carry_from_mem sampled in EXEC.
REQ-017 Carry SHALL be updated only by ADDWF (bit 16 of sum), SUBWF (1 = no borrow, i.e. M>=W), RLF (M[15]) and RRF (M[0]); all other ops SHALL hold it.
REQ-018 Zero SHALL be set to (R==0) for every legal op except MOVWF, which SHALL hold it.
REQ-019 carry_to_mem/zero_to_mem SHALL present the updated flags from the end of EXEC onward and SHALL hold them in all other states.
REQ-020 When dest=0, wreg SHALL load R at the end of EXEC, and mem_we SHALL stay low.
REQ-021 When dest=1, mem_we SHALL be 1 and mem_wdata=R, with mem_addr=operand_addr, for exactly the WB cycle.
REQ-022 When dest=1 and operand_addr==0x200 (W alias), wreg SHALL also load R at end of EXEC; mem_we SHALL still assert.
REQ-023 When dest=1 and operand_addr is 0x201 or 0x202, carry_to_mem/zero_to_mem SHALL take R[0] for the addressed flag instead of the REQ-017/018 value, so the ram flag is not overwritten by a stale value.
REQ-024 For opcode D-F, the block SHALL run the normal READ/EXEC/WB sequence with no wreg, flag or memory update, pulse illegal instead of done in WB, and keep mem_we low.
REQ-025 instr_valid while not in IDLE SHALL be ignored; inputs SHALL be captured at accept and not re-sampled.
REQ-026 mem_addr SHALL hold its last value in IDLE, and mem_we SHALL be 0 in every state except WB.

Reset
REQ-027 While reset is high, the block SHALL force state=IDLE, wreg=0, carry_to_mem=0, zero_to_mem=0, mem_addr=0, mem_wdata=0, mem_we=0, done=0, illegal=0, and instr_ready=0; instr_ready SHALL rise the first cycle after reset deasserts.
REQ-028 Reset asserted in any state, including WB, SHALL drop mem_we combinationally-asynchronously and abort the instruction with no W update.

Verification
REQ-029 The bench SHALL cover ADDWF: W=0xFFFF, M[0x010]=0x0001, dest=1 -> in WB, mem_we=1, addr=0x010, wdata=0x0000; then carry_to_mem=1, zero_to_mem=1, and done pulses at k+2.
REQ-030 The bench SHALL cover SUBWF: W=5, M=3, dest=0 -> wreg=0xFFFE, carry_to_mem=0, zero_to_mem=0, mem_we never high.
REQ-031 The bench SHALL cover RLF: carry_from_mem=1, M=0x8000, dest=0 -> wreg=0x0001, carry_to_mem=1.
REQ-032 The bench SHALL cover MOVWF to 0x202 with W=0x0003 -> zero_to_mem=1, mem_we=1, wdata=0x0003, and carry unchanged.
REQ-033 The bench SHALL cover opcode 0xE -> illegal pulses once, done stays 0, mem_we stays 0, and wreg/flags are unchanged.
REQ-034 The bench SHALL cover reset asserted mid-WB with dest=1 -> mem_we=0 within the same cycle, and after release wreg=0, instr_ready=1, and the next instruction completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fixed-latency READ/EXEC/WB sequencer around a 16-bit W-register ALU
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  opcode,
    input  logic [10:0] operand_addr,
    input  logic        dest,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        carry_from_mem,
    input  logic        zero_from_mem,
    output logic        carry_to_mem,
    output logic        zero_to_mem,
    output logic [15:0] wreg,
    output logic        done,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    localparam logic [10:0] W_ALIAS = 11'h200;
    localparam logic [10:0] C_ALIAS = 11'h201;
    localparam logic [10:0] Z_ALIAS = 11'h202;
    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        dest_q, dest_d;
    logic [10:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] wreg_q, wreg_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        ready_q, ready_d;
    logic [16:0] sum, diff;
    logic [15:0] res;
    logic        c_new, legal;
    logic        unused_zero_in;
    // Zero status from the ram is never consumed; the block always recomputes Z
    assign unused_zero_in = zero_from_mem;
    // ALU: result and new carry for the captured opcode against the fetched operand
    always_comb begin
        sum   = {1'b0, mem_rdata} + {1'b0, wreg_q};
        diff  = {1'b0, mem_rdata} - {1'b0, wreg_q};
        res   = 16'h0000;
        c_new = carry_q;
        legal = 1'b1;
        case (op_q)
            4'h0: res = mem_rdata;
            4'h1: res = wreg_q;
            4'h2: begin res = sum[15:0]; c_new = sum[16]; end
            4'h3: begin res = diff[15:0]; c_new = ~diff[16]; end
            4'h4: res = mem_rdata & wreg_q;
            4'h5: res = mem_rdata | wreg_q;
            4'h6: res = mem_rdata ^ wreg_q;
            4'h7: res = ~mem_rdata;
            4'h8: res = mem_rdata + 16'h0001;
            4'h9: res = mem_rdata - 16'h0001;
            4'hA: begin res = {mem_rdata[14:0], carry_from_mem}; c_new = mem_rdata[15]; end
            4'hB: begin res = {carry_from_mem, mem_rdata[15:1]}; c_new = mem_rdata[0]; end
            4'hC: res = 16'h0000;
            default: legal = 1'b0;
        endcase
    end
    // Sequencer next state: capture at accept, commit results at the end of EXEC
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dest_d      = dest_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wreg_d      = wreg_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            IDLE: if (instr_valid && ready_q) begin
                state_d    = READ;
                op_d       = opcode;
                dest_d     = dest || (opcode == 4'h1);
                mem_addr_d = operand_addr;
            end
            READ: state_d = EXEC;
            EXEC: begin
                state_d   = WB;
                done_d    = legal;
                illegal_d = ~legal;
                if (legal) begin
                    carry_d  = (dest_q && mem_addr_q == C_ALIAS) ? res[0] : c_new;
                    zero_d   = (dest_q && mem_addr_q == Z_ALIAS) ? res[0] : (op_q == 4'h1) ? zero_q : (res == 16'h0000);
                    wreg_d   = (!dest_q || mem_addr_q == W_ALIAS) ? res : wreg_q;
                    mem_we_d = dest_q;
                    mem_wdata_d = dest_q ? res : mem_wdata_q;
                end
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end
    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'h0;
            dest_q      <= 1'b0;
            mem_addr_q  <= 11'h000;
            mem_wdata_q <= 16'h0000;
            mem_we_q    <= 1'b0;
            wreg_q      <= 16'h0000;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wreg_q      <= wreg_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            ready_q     <= ready_d;
        end
    end
    assign instr_ready  = ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign wreg         = wreg_q;
    assign carry_to_mem = carry_q;
    assign zero_to_mem  = zero_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instruction runs against a flag/W/memory reference model
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  opcode = 4'h0;
    logic [10:0] operand_addr = 11'h000;
    logic        dest = 1'b0;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        cfm = 1'b0;
    logic        zfm = 1'b0;
    logic        carry_to_mem, zero_to_mem;
    logic [15:0] wreg;
    logic        done, illegal;
    logic [15:0] ram [0:2047];
    logic        ld_en = 1'b0;
    logic [10:0] ld_addr = 11'h000;
    logic [15:0] ld_data = 16'h0000;
    int          mref [0:2047];
    int          mw = 0, mc = 0, mz = 0;
    int          errors = 0, checks = 0;
    logic [10:0] addrs [0:15];

    alu_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand_addr(operand_addr), .dest(dest),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .carry_from_mem(cfm), .zero_from_mem(zfm), .carry_to_mem(carry_to_mem),
        .zero_to_mem(zero_to_mem), .wreg(wreg), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (ld_en) ram[ld_addr] <= ld_data;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [10:0] a, input logic [15:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v; mref[a] = int'(v);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [10:0] a, input logic d, input bit abort);
        int m, w, c, z, r, cin, n;
        bit dd, legal, we;
        m = mref[a]; w = mw; c = mc; z = mz; r = 0; cin = int'(cfm);
        dd = d || op == 4'h1;
        legal = op < 4'hD;
        case (op)
            4'h0: r = m;
            4'h1: r = w;
            4'h2: begin r = (m + w) % 65536; c = (m + w) / 65536; end
            4'h3: begin r = (m - w + 65536) % 65536; c = (m >= w) ? 1 : 0; end
            4'h4: r = m & w;
            4'h5: r = m | w;
            4'h6: r = m ^ w;
            4'h7: r = 65535 - m;
            4'h8: r = (m + 1) % 65536;
            4'h9: r = (m + 65535) % 65536;
            4'hA: begin r = (m * 2 + cin) % 65536; c = m / 32768; end
            4'hB: begin r = cin * 32768 + m / 2; c = m % 2; end
            default: r = 0;
        endcase
        we = legal && dd;
        if (legal) begin
            if (op != 4'h1) z = (r == 0) ? 1 : 0;
            if (dd && a == 11'h201) c = r % 2;
            if (dd && a == 11'h202) z = r % 2;
            if (!dd || a == 11'h200) w = r;
        end else begin
            c = mc; z = mz;
        end
        instr_valid = 1'b1; opcode = op; operand_addr = a; dest = d;
        n = 0;
        while (!instr_ready && n < 10) begin @(posedge clk); #1; n++; end
        chk("ready_before_accept", instr_ready, 1);
        @(posedge clk); #1;
        opcode = 4'($urandom); operand_addr = 11'($urandom); dest = 1'($urandom);
        chk("read_ready", instr_ready, 0);
        chk("read_addr", mem_addr, a);
        chk("read_we", mem_we, 0);
        chk("read_done", done, 0);
        @(posedge clk); #1;
        chk("exec_we", mem_we, 0);
        chk("exec_done", done, 0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("wb_done", done, legal);
        chk("wb_illegal", illegal, !legal);
        chk("wb_we", mem_we, we);
        chk("wb_addr", mem_addr, a);
        if (we) chk("wb_wdata", mem_wdata, r);
        chk("wb_wreg", wreg, w);
        chk("wb_carry", carry_to_mem, c);
        chk("wb_zero", zero_to_mem, z);
        if (abort) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_we", mem_we, 0);
            chk("abort_wreg", wreg, 0);
            chk("abort_ready", instr_ready, 0);
            chk("abort_done", done, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            mw = 0; mc = 0; mz = 0;
            @(posedge clk); #1;
            chk("abort_ready_after", instr_ready, 1);
            chk("abort_wreg_after", wreg, 0);
        end else begin
            mw = w; mc = c; mz = z;
            if (we) mref[a] = r;
            @(posedge clk); #1;
            chk("idle_done", done, 0);
            chk("idle_illegal", illegal, 0);
            chk("idle_we", mem_we, 0);
            chk("idle_ready", instr_ready, 1);
        end
    endtask

    initial begin
        addrs[0] = 11'h010; addrs[1] = 11'h011; addrs[2] = 11'h012; addrs[3] = 11'h020;
        addrs[4] = 11'h021; addrs[5] = 11'h022; addrs[6] = 11'h200; addrs[7] = 11'h201;
        addrs[8] = 11'h202; addrs[9] = 11'h030; addrs[10] = 11'h031; addrs[11] = 11'h032;
        addrs[12] = 11'h033; addrs[13] = 11'h034; addrs[14] = 11'h035; addrs[15] = 11'h000;
        for (int i = 9; i < 16; i++) load(addrs[i], 16'($urandom));
        load(11'h200, 16'h1234); load(11'h201, 16'h0000); load(11'h202, 16'h0001);
        load(11'h010, 16'h0001); load(11'h011, 16'h0003); load(11'h012, 16'h8000);
        load(11'h020, 16'hFFFF); load(11'h021, 16'h0005); load(11'h022, 16'h0003);
        chk("rst_wreg", wreg, 0);
        chk("rst_carry", carry_to_mem, 0);
        chk("rst_zero", zero_to_mem, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ready", instr_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", instr_ready, 1);
        run(4'h0, 11'h020, 1'b0, 1'b0);
        run(4'h2, 11'h010, 1'b1, 1'b0);
        chk("addwf_carry", carry_to_mem, 1);
        chk("addwf_zero", zero_to_mem, 1);
        run(4'h0, 11'h021, 1'b0, 1'b0);
        run(4'h3, 11'h011, 1'b0, 1'b0);
        chk("subwf_wreg", wreg, 16'hFFFE);
        chk("subwf_carry", carry_to_mem, 0);
        cfm = 1'b1;
        run(4'hA, 11'h012, 1'b0, 1'b0);
        chk("rlf_wreg", wreg, 16'h0001);
        chk("rlf_carry", carry_to_mem, 1);
        run(4'h0, 11'h022, 1'b0, 1'b0);
        run(4'h1, 11'h202, 1'b0, 1'b0);
        chk("movwf_zero", zero_to_mem, 1);
        chk("movwf_carry", carry_to_mem, 1);
        run(4'hE, 11'h010, 1'b1, 1'b0);
        chk("illegal_wreg", wreg, 16'h0003);
        for (int i = 0; i < 40; i++) begin
            cfm = 1'($urandom);
            run(4'($urandom_range(0, 15)), addrs[$urandom_range(0, 15)], 1'($urandom), 1'b0);
        end
        run(4'h2, 11'h030, 1'b1, 1'b1);
        run(4'h0, 11'h010, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
